// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU for the EX stage.
//   Single-cycle ops (add/sub/logic/shift/rotate/lui) finish one cycle after start.
//   MULT/MULTU/DIV/DIVU iterate WIDTH cycles, then take one sign-fix cycle. The
//   result is written into HI/LO.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start, op, a, b  issue; accepted only while busy=0; operands latched at start
//   busy             op in flight (cycle after start .. done cycle inclusive)
//   done             one-cycle completion pulse
//   result           single-cycle result (held)
//   hi, lo           mul: {hi,lo}=product; div: lo=quotient, hi=remainder
//   overflow         signed ADD/SUB overflow, valid with done
//   div_zero         divide by zero, valid with done
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overflow,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t               state;
  logic [1:0]           op_r;     // op[1]=divide, op[0]=unsigned
  logic [WIDTH-1:0]     a_r;      // original dividend, returned on divide by zero
  logic [WIDTH-1:0]     d_r;      // multiplicand / divisor magnitude
  logic [WIDTH:0]       acc;      // product high half / partial remainder
  logic [WIDTH-1:0]     lo_w;     // multiplier / dividend shifting into quotient
  logic [SHAMT_W-1:0]   cnt;
  logic                 neg_lo, neg_hi;

  // ---------------- single-cycle datapath ----------------
  logic [SHAMT_W-1:0]   sh, nsh;
  logic [WIDTH:0]       sum_s, dif_s;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ovf;

  assign sh    = a[SHAMT_W-1:0];
  assign nsh   = SHAMT_W'(0) - sh;      // WIDTH-sh modulo WIDTH, for the rotate
  assign sum_s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign dif_s = {a[WIDTH-1], a} - {b[WIDTH-1], b};

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      4'b0000: alu_res = a + b;
      4'b0001: alu_res = a & b;
      4'b0010: alu_res = a ^ b;
      4'b0011: alu_res = b << sh;
      4'b0100: begin alu_res = dif_s[WIDTH-1:0]; alu_ovf = dif_s[WIDTH] ^ dif_s[WIDTH-1]; end
      4'b0101: alu_res = a | b;
      4'b0110: alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b0111: alu_res = b >> sh;
      4'b1000: alu_res = a - b;
      4'b1001: begin alu_res = sum_s[WIDTH-1:0]; alu_ovf = sum_s[WIDTH] ^ sum_s[WIDTH-1]; end
      4'b1010: alu_res = (sh == '0) ? b : ((b >> sh) | (b << nsh));
      4'b1011: alu_res = $signed(b) >>> sh;
      default: alu_res = '0;
    endcase
  end

  // ---------------- mul/div operand magnitudes ----------------
  logic                 op_sgn;
  logic [WIDTH-1:0]     mag_a, mag_b;

  assign op_sgn = ~op[0];
  assign mag_a  = (op_sgn && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
  assign mag_b  = (op_sgn && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;

  // ---------------- iteration steps ----------------
  // Shift-add multiply: add multiplicand when the multiplier LSB is set, then
  // shift {acc,lo_w} right. Restoring divide: shift a dividend bit into the
  // remainder, and keep the trial subtraction when it does not borrow.
  logic [WIDTH:0]       mul_sum, div_r, div_t;
  logic [2*WIDTH-1:0]   prod, prod_fix;

  assign mul_sum  = {1'b0, acc[WIDTH-1:0]} + (lo_w[0] ? {1'b0, d_r} : '0);
  assign div_r    = {acc[WIDTH-1:0], lo_w[WIDTH-1]};
  assign div_t    = div_r - {1'b0, d_r};
  assign prod     = {acc[WIDTH-1:0], lo_w};
  assign prod_fix = neg_lo ? ((2*WIDTH)'(0) - prod) : prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      hi       <= '0;
      lo       <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
      op_r     <= '0;
      a_r      <= '0;
      d_r      <= '0;
      acc      <= '0;
      lo_w     <= '0;
      cnt      <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (!(op[3] && op[2])) begin
            result   <= alu_res;
            overflow <= alu_ovf;
            div_zero <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            op_r   <= op[1:0];
            a_r    <= a;
            d_r    <= mag_b;
            acc    <= '0;
            lo_w   <= mag_a;
            cnt    <= '0;
            // MULT: negate the product; DIV: negate the quotient on a sign mismatch
            neg_lo <= op_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            // remainder follows the dividend sign
            neg_hi <= op_sgn & a[WIDTH-1];
            state  <= ITER;
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (op_r[1]) begin
            if (!div_t[WIDTH]) begin
              acc  <= div_t;
              lo_w <= {lo_w[WIDTH-2:0], 1'b1};
            end else begin
              acc  <= div_r;
              lo_w <= {lo_w[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc  <= {1'b0, mul_sum[WIDTH:1]};
            lo_w <= {mul_sum[0], lo_w[WIDTH-1:1]};
          end
          if (cnt == '1) state <= FIX;
        end
        FIX: begin
          overflow <= 1'b0;
          div_zero <= 1'b0;
          if (!op_r[1]) begin
            {hi, lo} <= prod_fix;
          end else if (d_r == '0) begin
            lo       <= '1;
            hi       <= a_r;
            div_zero <= 1'b1;
          end else begin
            lo <= neg_lo ? (WIDTH'(0) - lo_w) : lo_w;
            hi <= neg_hi ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: random and directed checks of seq_alu (WIDTH=32) against a
// plain-arithmetic reference model.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, overflow, div_zero;
  logic [31:0] result, hi, lo;

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_res = '0, exp_hi = '0, exp_lo = '0;

  seq_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo),
    .overflow(overflow), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op in the next cycle and check timing and all outputs against the model.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit poke);
    longint      sx, sy, v, q, r;
    logic [63:0] bb, p;
    logic signed [31:0] ys;
    logic [4:0]  s;
    bit          ovf, dz;
    int          lat, exp_lat;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s  = x[4:0];
    ovf = 1'b0; dz = 1'b0;
    exp_lat = (o >= 4'd12) ? 34 : 1;
    case (o)
      4'd0:  exp_res = x + y;
      4'd1:  exp_res = x & y;
      4'd2:  exp_res = x ^ y;
      4'd3:  exp_res = y << s;
      4'd4:  begin v = sx - sy; exp_res = 32'(v); ovf = (v > 64'sd2147483647) || (v < -64'sd2147483648); end
      4'd5:  exp_res = x | y;
      4'd6:  exp_res = {y[15:0], 16'h0000};
      4'd7:  exp_res = y >> s;
      4'd8:  exp_res = x - y;
      4'd9:  begin v = sx + sy; exp_res = 32'(v); ovf = (v > 64'sd2147483647) || (v < -64'sd2147483648); end
      4'd10: begin bb = {y, y} >> s; exp_res = bb[31:0]; end
      4'd11: begin ys = y; exp_res = ys >>> s; end
      4'd12: begin v = sx * sy; {exp_hi, exp_lo} = v; end
      4'd13: begin p = {32'h0, x} * {32'h0, y}; {exp_hi, exp_lo} = p; end
      4'd14: if (y == 0) begin exp_lo = '1; exp_hi = x; dz = 1'b1; end
             else begin q = sx / sy; r = sx % sy; exp_lo = 32'(q); exp_hi = 32'(r); end
      default: if (y == 0) begin exp_lo = '1; exp_hi = x; dz = 1'b1; end
               else begin exp_lo = x / y; exp_hi = x % y; end
    endcase

    @(negedge clk);
    check("idle_busy", {63'b0, busy}, 64'd0);
    check("idle_done", {63'b0, done}, 64'd0);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    // operand changes while busy must have no effect
    op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    forever begin
      @(negedge clk);
      if (done) break;
      start = poke && (lat == 4);
      if (start) begin op = 4'($urandom); a = $urandom; b = $urandom; end
      lat++;
      if (lat > 60) break;
    end
    start = 1'b0;
    check($sformatf("latency op%0d", o), 64'(lat), 64'(exp_lat));
    check("busy_at_done", {63'b0, busy}, 64'd1);
    check($sformatf("result op%0d", o), {32'b0, result}, {32'b0, exp_res});
    check($sformatf("hilo op%0d", o), {hi, lo}, {exp_hi, exp_lo});
    check($sformatf("ovf op%0d", o), {63'b0, overflow}, {63'b0, ovf});
    check($sformatf("dz op%0d", o), {63'b0, div_zero}, {63'b0, dz});
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_outs", {result, hi}, 64'd0);
    check("rst_lo_flags", {lo, 30'b0, overflow, div_zero}, 64'd0);
    rst_n = 1'b1;

    // directed corners
    run_op(4'd9,  32'h7FFFFFFF, 32'h1, 0);
    run_op(4'd0,  32'h7FFFFFFF, 32'h1, 0);
    run_op(4'd4,  32'h80000000, 32'h1, 0);
    run_op(4'd10, 32'd1, 32'h00000001, 0);
    run_op(4'd11, 32'd31, 32'h80000000, 0);
    run_op(4'd10, 32'd0, 32'h12345678, 0);
    run_op(4'd3,  32'd0, 32'h9ABCDEF0, 0);
    run_op(4'd6,  32'd5, 32'hDEADBEEF, 0);
    run_op(4'd12, 32'hFFFFFFFD, 32'd7, 1);
    run_op(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    run_op(4'd14, 32'hFFFFFFF9, 32'd2, 0);
    run_op(4'd15, 32'd7, 32'd0, 0);
    run_op(4'd14, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(4'd14, 32'hFFFFFFF9, 32'd0, 0);
    run_op(4'd12, 32'h80000000, 32'h80000000, 1);

    // reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; op = 4'd13; a = 32'h1234; b = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy_done", {62'b0, busy, done}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_result", {32'b0, result}, 64'd0);
    exp_res = '0; exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd13, 32'd6, 32'd7, 0);

    // random ops, biased toward the awkward operands
    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(ro, ra, rb, bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
